// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, the arbiter and the
// register file write port.
//   flush                    : synchronous clear of queued and in-flight writes
//   sN_valid/ready/addr/data : per-source push handshake (N = 0 ALU, 1 load unit)
//   rf_we/rf_wa/rf_wd        : registered register file write port
//   pend_mask                : bit r set while a write to xr is queued or on rf_*
//   idle                     : both FIFOs empty and rf_we low
// master = producer/consumer side (pipeline), slave = arbiter.
interface regfile_wb_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          flush;
  logic          s0_valid;
  logic          s0_ready;
  logic [AW-1:0] s0_addr;
  logic [DW-1:0] s0_data;
  logic          s1_valid;
  logic          s1_ready;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_data;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [31:0]   pend_mask;
  logic          idle;

  modport master (
    output flush, s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data,
    input  s0_ready, s1_ready, rf_we, rf_wa, rf_wd, pend_mask, idle
  );

  modport slave (
    input  flush, s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data,
    output s0_ready, s1_ready, rf_we, rf_wa, rf_wd, pend_mask, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file writeback arbiter: two writeback sources (0 = ALU, 1 = load
// unit) each push address/data pairs into a private DEPTH-entry FIFO; one
// entry per cycle is granted and written to the registered rf_* port.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : regfile_wb_arbiter_if.slave (handshakes, flush, rf port, pend_mask, idle)
// Configuration macro: REGFILE_WB_ARB_FIXED_PRIO_EN
//   defined   -> source 1 always wins contention (no round-robin state)
//   undefined -> round-robin between the sources
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic                clk,
  input logic                rst,
  regfile_wb_arbiter_if.slave bus
);
  // Pointers carry one extra MSB so full and empty are distinguishable.
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [AW-1:0] q_addr [2][DEPTH];
  logic [DW-1:0] q_data [2][DEPTH];
  logic [PW-1:0] wp [2];
  logic [PW-1:0] rp [2];
  logic [1:0]    empty;
  logic [1:0]    full;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    in_valid;
  logic [AW-1:0] in_addr [2];
  logic [DW-1:0] in_data [2];

  logic          grant;
  logic          gsrc;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  logic          rf_we_reg;
  logic [AW-1:0] rf_wa_reg;
  logic [DW-1:0] rf_wd_reg;
  logic [31:0]   mask;

  assign in_valid   = {bus.s1_valid, bus.s0_valid};
  assign in_addr[0] = bus.s0_addr;
  assign in_addr[1] = bus.s1_addr;
  assign in_data[0] = bus.s0_data;
  assign in_data[1] = bus.s1_data;

  // FIFO status, handshake qualification and pop selection.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      empty[i] = (wp[i] == rp[i]);
      full[i]  = (wp[i][PW-1] != rp[i][PW-1]) && (wp[i][IW-1:0] == rp[i][IW-1:0]);
      // ready never looks at the same-cycle pop, so no pass-through path
      push[i]  = in_valid[i] && !full[i] && !bus.flush;
      pop[i]   = grant && (gsrc == i[0]) && !bus.flush;
    end
  end

  assign bus.s0_ready = !full[0] && !bus.flush;
  assign bus.s1_ready = !full[1] && !bus.flush;

`ifdef REGFILE_WB_ARB_FIXED_PRIO_EN
  // Fixed priority: the load unit wins whenever it has an entry.
  always_comb begin
    grant = 1'b0;
    gsrc  = 1'b0;
    if (!empty[1]) begin
      grant = 1'b1;
      gsrc  = 1'b1;
    end else if (!empty[0]) begin
      grant = 1'b1;
      gsrc  = 1'b0;
    end else begin
      grant = 1'b0;
      gsrc  = 1'b0;
    end
    head_addr = q_addr[gsrc][rp[gsrc][IW-1:0]];
    head_data = q_data[gsrc][rp[gsrc][IW-1:0]];
  end
`else
  logic last_grant;

  // Round-robin: under contention grant the source that did not win last.
  always_comb begin
    grant = 1'b0;
    gsrc  = 1'b0;
    if (!empty[0] && !empty[1]) begin
      grant = 1'b1;
      gsrc  = ~last_grant;
    end else if (!empty[0]) begin
      grant = 1'b1;
      gsrc  = 1'b0;
    end else if (!empty[1]) begin
      grant = 1'b1;
      gsrc  = 1'b1;
    end else begin
      grant = 1'b0;
      gsrc  = 1'b0;
    end
    head_addr = q_addr[gsrc][rp[gsrc][IW-1:0]];
    head_data = q_data[gsrc][rp[gsrc][IW-1:0]];
  end

  // Round-robin pointer; x0 discards count as grants, flush leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant && !bus.flush) begin
      last_grant <= gsrc;
    end
  end
`endif

  // FIFO storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          q_addr[i][j] <= '0;
          q_data[i][j] <= '0;
        end
      end
    end else if (bus.flush) begin
      for (int i = 0; i < 2; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          q_addr[i][wp[i][IW-1:0]] <= in_addr[i];
          q_data[i][wp[i][IW-1:0]] <= in_data[i];
          wp[i] <= wp[i] + PTR_ONE;
        end
        if (pop[i]) begin
          rp[i] <= rp[i] + PTR_ONE;
        end
      end
    end
  end

  // Registered write port; a granted x0 entry is dropped without a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_reg <= 1'b0;
      rf_wa_reg <= '0;
      rf_wd_reg <= '0;
    end else if (bus.flush) begin
      rf_we_reg <= 1'b0;
    end else if (grant) begin
      rf_we_reg <= (head_addr != '0);
      if (head_addr != '0) begin
        rf_wa_reg <= head_addr;
        rf_wd_reg <= head_data;
      end
    end else begin
      rf_we_reg <= 1'b0;
    end
  end

  // Pending mask: every occupied FIFO slot plus the write on the rf port.
  always_comb begin
    mask = 32'd0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        // slot j is occupied when its distance from rp is below the occupancy
        mask = mask | ((({1'b0, IW'(j) - rp[i][IW-1:0]}) < (wp[i] - rp[i]))
                       ? (32'd1 << q_addr[i][j]) : 32'd0);
      end
    end
    mask = mask | (rf_we_reg ? (32'd1 << rf_wa_reg) : 32'd0);
    mask[0] = 1'b0;
  end

  assign bus.rf_we     = rf_we_reg;
  assign bus.rf_wa     = rf_wa_reg;
  assign bus.rf_wd     = rf_wd_reg;
  assign bus.pend_mask = mask;
  assign bus.idle      = empty[0] && empty[1] && !rf_we_reg;
endmodule
